// File: rtl/fetch_stage_pkg.sv
// Shared fetch/decode definitions: FSM encoding, the injected NOP and the opcode classes.
// The long-opcode test is also provided here so that decode can reuse it.
package fetch_stage_pkg;

  typedef enum logic {
    S_OP  = 1'b0,
    S_IMM = 1'b1
  } fetch_state_e;

  localparam logic [7:0] NOP_OPCODE      = 8'h00;
  localparam logic [3:0] LONG_MASK_DFLT  = 4'hC;
  localparam logic [3:0] LONG_MATCH_DFLT = 4'hC;

  // Jump-class upper nibbles, shared with decode and PC control.
  // All of them satisfy the default long test.
  localparam logic [3:0] OPC_JMP  = 4'hC;
  localparam logic [3:0] OPC_JZ   = 4'hD;
  localparam logic [3:0] OPC_JNZ  = 4'hE;
  localparam logic [3:0] OPC_CALL = 4'hF;

  function automatic logic is_long_nib(input logic [3:0] nib,
                                       input logic [3:0] mask,
                                       input logic [3:0] match);
    return (nib & mask) == match;
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Bundle between the fetch stage, the program ROM / PC unit and stage 2.
interface fetch_stage_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 8
);
  logic [ADDR_W-1:0] pc;
  logic [DATA_W-1:0] rom_data;
  logic              stall;
  logic              flush;
  logic              pc_inc;
  logic [DATA_W-1:0] instruction_out;
  logic [DATA_W-1:0] d_bus_imm;
  logic              ir_valid;
  logic              ir_long;
  logic [ADDR_W-1:0] ir_pc;

  modport master (
    output pc, rom_data, stall, flush,
    input  pc_inc, instruction_out, d_bus_imm, ir_valid, ir_long, ir_pc
  );

  modport slave (
    input  pc, rom_data, stall, flush,
    output pc_inc, instruction_out, d_bus_imm, ir_valid, ir_long, ir_pc
  );
endinterface

// File: rtl/fetch_stage_long_op_detect.sv
// Combinational opcode classifier that flags a 2-byte instruction from its upper nibble.
// Decode reuses this classifier.
module long_op_detect
  import fetch_stage_pkg::*;
#(
  parameter logic [3:0] LONG_MASK  = LONG_MASK_DFLT,
  parameter logic [3:0] LONG_MATCH = LONG_MATCH_DFLT
) (
  input  logic [3:0] op_hi,
  output logic       is_long
);

  assign is_long = is_long_nib(op_hi, LONG_MASK, LONG_MATCH);

endmodule

// File: rtl/fetch_stage.sv
// Stage-1 fetch/IR: assembles 1- or 2-byte instructions from the ROM byte stream.
// A flush overrides a stall and discards any pending opcode byte.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int          ADDR_W     = 12,
  parameter int          DATA_W     = 8,
  parameter logic [3:0]  LONG_MASK  = LONG_MASK_DFLT,
  parameter logic [3:0]  LONG_MATCH = LONG_MATCH_DFLT,
  parameter logic [DATA_W-1:0] NOP_OP = NOP_OPCODE
) (
  input logic          clock,
  input logic          reset,
  fetch_stage_if.slave bus
);

  fetch_state_e      state_p0;
  logic [DATA_W-1:0] pending_op_p0;
  logic [ADDR_W-1:0] pending_pc_p0;
  logic              is_long;

  long_op_detect #(
    .LONG_MASK  (LONG_MASK),
    .LONG_MATCH (LONG_MATCH)
  ) u_long_op_detect (
    .op_hi   (bus.rom_data[DATA_W-1 -: 4]),
    .is_long (is_long)
  );

  // Each state consumes exactly one byte, so the PC only stops on a stall.
  assign bus.pc_inc = !bus.stall | bus.flush;

  // ROM byte -> IR boundary
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_p0            <= S_OP;
      bus.instruction_out <= NOP_OP;
      bus.d_bus_imm       <= '0;
      bus.ir_valid        <= 1'b0;
      bus.ir_long         <= 1'b0;
      bus.ir_pc           <= '0;
      pending_op_p0       <= '0;
      pending_pc_p0       <= '0;
    end else if (bus.flush) begin
      state_p0            <= S_OP;
      bus.instruction_out <= NOP_OP;
      bus.ir_valid        <= 1'b0;
      bus.ir_long         <= 1'b0;
    end else if (!bus.stall) begin
      case (state_p0)
        S_OP: begin
          if (is_long) begin
            pending_op_p0 <= bus.rom_data;
            pending_pc_p0 <= bus.pc;
            bus.ir_valid  <= 1'b0;
            state_p0      <= S_IMM;
          end else begin
            bus.instruction_out <= bus.rom_data;
            bus.ir_long         <= 1'b0;
            bus.ir_pc           <= bus.pc;
            bus.ir_valid        <= 1'b1;
          end
        end
        S_IMM: begin
          bus.instruction_out <= pending_op_p0;
          bus.d_bus_imm       <= bus.rom_data;
          bus.ir_long         <= 1'b1;
          bus.ir_pc           <= pending_pc_p0;
          bus.ir_valid        <= 1'b1;
          state_p0            <= S_OP;
        end
        default: state_p0 <= S_OP;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: ROM array plus a small PC-unit model, hand-computed IR values.
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  logic clock = 1'b0;
  logic reset;
  int   n_vec = 0;
  int   n_bad = 0;

  logic [7:0] rom [4096];

  fetch_stage_if #(.ADDR_W(12), .DATA_W(8)) bus ();

  fetch_stage dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  assign bus.rom_data = rom[bus.pc];

  task automatic chk_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_ir(input string tag, input logic [7:0] ins, input logic [7:0] imm,
                        input logic vld, input logic lng, input logic [11:0] ipc);
    chk_vec({tag, ".instr"}, 32'(bus.instruction_out), 32'(ins));
    chk_vec({tag, ".imm"},   32'(bus.d_bus_imm),       32'(imm));
    chk_vec({tag, ".valid"}, 32'(bus.ir_valid),        32'(vld));
    chk_vec({tag, ".long"},  32'(bus.ir_long),         32'(lng));
    chk_vec({tag, ".ir_pc"}, 32'(bus.ir_pc),           32'(ipc));
  endtask

  // One clock with the given controls; the PC-unit model loads on flush, else advances unless stalled.
  task automatic tick(input string tag, input logic st, input logic fl, input logic [11:0] tgt);
    logic [11:0] nxt;
    bus.stall = st;
    bus.flush = fl;
    #1;
    chk_vec({tag, ".pc_inc"}, 32'(bus.pc_inc), 32'(!st | fl));
    nxt = fl ? tgt : (st ? bus.pc : bus.pc + 12'd1);
    @(posedge clock);
    #1;
    bus.pc = nxt;
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) rom[i] = 8'h00;
    rom[12'h000] = 8'h12;
    rom[12'h001] = 8'h34;
    rom[12'h002] = 8'h21;
    rom[12'h003] = 8'h56;
    rom[12'h010] = 8'hC5;
    rom[12'h011] = 8'hA7;
    rom[12'h012] = 8'hD0;
    rom[12'h013] = 8'h99;
    rom[12'h200] = 8'h31;
    rom[12'hFFF] = 8'hC3;

    reset     = 1'b1;
    bus.pc    = 12'h000;
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    #1;
    chk_ir("reset", 8'h00, 8'h00, 1'b0, 1'b0, 12'h000);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;

    tick("s0", 1'b0, 1'b0, 12'h000); chk_ir("s0", 8'h12, 8'h00, 1'b1, 1'b0, 12'h000);
    tick("s1", 1'b0, 1'b0, 12'h000); chk_ir("s1", 8'h34, 8'h00, 1'b1, 1'b0, 12'h001);
    tick("s2", 1'b0, 1'b0, 12'h000); chk_ir("s2", 8'h21, 8'h00, 1'b1, 1'b0, 12'h002);

    for (int i = 0; i < 3; i++) begin
      tick("stall", 1'b1, 1'b0, 12'h000);
      chk_ir("stall", 8'h21, 8'h00, 1'b1, 1'b0, 12'h002);
    end
    tick("release", 1'b0, 1'b0, 12'h000); chk_ir("release", 8'h56, 8'h00, 1'b1, 1'b0, 12'h003);

    tick("fl010", 1'b0, 1'b1, 12'h010);  chk_ir("fl010", 8'h00, 8'h00, 1'b0, 1'b0, 12'h003);
    tick("op_c5", 1'b0, 1'b0, 12'h000);  chk_ir("op_c5", 8'h00, 8'h00, 1'b0, 1'b0, 12'h003);
    tick("imm_a7", 1'b0, 1'b0, 12'h000); chk_ir("imm_a7", 8'hC5, 8'hA7, 1'b1, 1'b1, 12'h010);
    chk_vec("target", 32'({bus.instruction_out[3:0], bus.d_bus_imm}), 32'h5A7);

    tick("op_d0", 1'b0, 1'b0, 12'h000);  chk_ir("op_d0", 8'hC5, 8'hA7, 1'b0, 1'b1, 12'h010);
    tick("flst", 1'b1, 1'b1, 12'h200);   chk_ir("flst", 8'h00, 8'hA7, 1'b0, 1'b0, 12'h010);
    tick("op_31", 1'b0, 1'b0, 12'h000);  chk_ir("op_31", 8'h31, 8'hA7, 1'b1, 1'b0, 12'h200);

    tick("flfff", 1'b0, 1'b1, 12'hFFF);  chk_ir("flfff", 8'h00, 8'hA7, 1'b0, 1'b0, 12'h200);
    tick("op_c3", 1'b0, 1'b0, 12'h000);  chk_ir("op_c3", 8'h00, 8'hA7, 1'b0, 1'b0, 12'h200);
    chk_vec("wrap_pc", 32'(bus.pc), 32'h000);
    tick("imm_wr", 1'b0, 1'b0, 12'h000); chk_ir("imm_wr", 8'hC3, 8'h12, 1'b1, 1'b1, 12'hFFF);

    tick("fl010b", 1'b0, 1'b1, 12'h010); chk_ir("fl010b", 8'h00, 8'h12, 1'b0, 1'b0, 12'hFFF);
    tick("op_c5b", 1'b0, 1'b0, 12'h000); chk_ir("op_c5b", 8'h00, 8'h12, 1'b0, 1'b0, 12'hFFF);

    #2;
    reset = 1'b1;
    #1;
    chk_ir("arst", 8'h00, 8'h00, 1'b0, 1'b0, 12'h000);
    bus.pc = 12'h000;
    @(negedge clock);
    reset = 1'b0;
    tick("restart", 1'b0, 1'b0, 12'h000); chk_ir("restart", 8'h12, 8'h00, 1'b1, 1'b0, 12'h000);
    tick("restart2", 1'b0, 1'b0, 12'h000); chk_ir("restart2", 8'h34, 8'h00, 1'b1, 1'b0, 12'h001);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
